// File: rtl/cmd_buffer_pkg.sv
// Shared defaults, watchdog state encoding and a width helper for the
// UART command buffer and its idle watchdog.
package cmd_buffer_pkg;

  // FIFO capacity in bytes (power of two, at least 2).
  localparam int DEPTH_DEFAULT = 8;

  // Idle clock cycles before a stop byte is injected (0.5 s at 50 MHz).
  localparam int WDOG_CYCLES_DEFAULT = 25_000_000;

  // Byte the watchdog drops into the FIFO when the command stream goes quiet ('S').
  localparam logic [7:0] STOP_CHAR_DEFAULT = 8'h53;

  // ARMED:   counting idle cycles
  // PENDING: idle limit reached, waiting for a slot to write the stop byte
  // SPENT:   stop byte already written for this idle period
  typedef enum logic [1:0] {
    WDOG_ARMED   = 2'd0,
    WDOG_PENDING = 2'd1,
    WDOG_SPENT   = 2'd2
  } wdog_state_t;

  // Number of bits needed to index 'count' distinct values, never less than one.
  function automatic int ptr_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/cmd_buffer_wdog.sv
// Idle watchdog for the UART command buffer. Counts cycles without an accepted
// input byte and requests a single stop-byte injection once the idle limit is
// reached. A real byte always wins over the injection and re-arms the watchdog.
module cmd_buffer_wdog
  import cmd_buffer_pkg::*;
#(
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_accept,
  input  logic in_valid,
  input  logic fifo_full,
  output logic inject
);

  localparam int CW = ptr_width(WDOG_CYCLES);
  localparam logic [CW-1:0] COUNT_MAX = CW'(WDOG_CYCLES - 1);

  logic [CW-1:0] idle_count;
  wdog_state_t   state_q;
  wdog_state_t   state_d;

  // Idle counter: cleared by every accepted byte, otherwise counts up and sticks at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_count <= '0;
    end else if (in_accept) begin
      idle_count <= '0;
    end else if (idle_count != COUNT_MAX) begin
      idle_count <= idle_count + CW'(1);
    end
  end

  // Watchdog state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WDOG_ARMED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and injection request; the injection yields to any real byte on in_valid.
  always_comb begin
    state_d = state_q;
    inject  = 1'b0;
    case (state_q)
      WDOG_ARMED: begin
        if (!in_accept && (idle_count == COUNT_MAX)) begin
          state_d = WDOG_PENDING;
        end
      end
      WDOG_PENDING: begin
        if (in_accept) begin
          state_d = WDOG_ARMED;
        end else if (!fifo_full && !in_valid) begin
          inject  = 1'b1;
          state_d = WDOG_SPENT;
        end
      end
      WDOG_SPENT: begin
        if (in_accept) begin
          state_d = WDOG_ARMED;
        end
      end
      default: begin
        state_d = WDOG_ARMED;
      end
    endcase
  end

endmodule

// File: rtl/uart_cmd_buffer.sv
// First-word-fall-through byte FIFO placed between the command translator
// (ascii_out / cmd_ready) and the UART transmitter (data_tx / valid / tx_ready).
// An idle watchdog appends a single STOP_CHAR when commands stop arriving, so the
// far end always sees a stop command after the stream goes quiet.
module uart_cmd_buffer
  import cmd_buffer_pkg::*;
#(
  parameter int         DEPTH       = DEPTH_DEFAULT,
  parameter int         WDOG_CYCLES = WDOG_CYCLES_DEFAULT,
  parameter logic [7:0] STOP_CHAR   = STOP_CHAR_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   high_water,
  output logic                   wdog_fired
);

  // DEPTH is a power of two, so pointers wrap modulo DEPTH by plain overflow.
  localparam int AW = ptr_width(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          full;
  logic          push;
  logic          pop;
  logic          inject;
  logic          write_en;
  logic [7:0]    write_byte;

  // Handshakes come only from registered occupancy, so in_ready never depends on out_ready.
  assign full       = (level_q == LEVEL_FULL);
  assign in_ready   = !full;
  assign out_valid  = (level_q != '0);
  assign out_data   = mem[rd_ptr];
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign write_en   = push || inject;
  assign write_byte = push ? in_data : STOP_CHAR;
  assign level      = level_q;
  assign wdog_fired = inject;

  cmd_buffer_wdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_accept (push),
    .in_valid  (in_valid),
    .fifo_full (full),
    .inject    (inject)
  );

  // Occupancy update; a simultaneous write and read leaves the level unchanged.
  always_comb begin
    level_d = level_q;
    case ({write_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Byte storage; contents survive reset because the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wr_ptr] <= write_byte;
    end
  end

  // Write pointer advances on every stored byte, real or injected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (write_en) begin
      wr_ptr <= wr_ptr + AW'(1);
    end
  end

  // Read pointer advances on every byte taken by the transmitter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Stored byte count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  // Sticky flag recording that the buffer has ever been completely full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_water <= 1'b0;
    end else if (level_d == LEVEL_FULL) begin
      high_water <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_buffer.sv
// Scoreboard bench for uart_cmd_buffer: bytes are queued as they are pushed
// (or when a stop byte is due) and checked in order as the transmitter takes them.
module tb_uart_cmd_buffer;

  localparam int         DEPTH = 8;
  localparam int         WDOG  = 16;
  localparam logic [7:0] STOP  = 8'h53;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] level;
  logic       high_water;
  logic       wdog_fired;

  logic [7:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;

  uart_cmd_buffer #(
    .DEPTH       (DEPTH),
    .WDOG_CYCLES (WDOG),
    .STOP_CHAR   (STOP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .high_water (high_water),
    .wdog_fired (wdog_fired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] time limit expired");
  end

  // Output monitor: every byte taken by the transmitter must match the queue head.
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL scoreboard_extra: got byte %h, required no byte", out_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (out_data !== exp_b) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_order: got %h, required %h", out_data, exp_b);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    vectors++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_drain: got out_valid=%b pending=%0d, required out_valid=0 pending=0",
               name, out_valid, exp_q.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    #2;
    rst_n = 1'b0;
    #2;
    vectors++;
    if (level !== 4'd0 || out_valid !== 1'b0 || high_water !== 1'b0 || wdog_fired !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got level=%0d valid=%b hw=%b wf=%b, required 0 0 0 0",
               level, out_valid, high_water, wdog_fired);
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_order();
    logic [7:0] seq [3];
    seq = '{8'h46, 8'h4C, 8'h52};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = seq[i];
      exp_q.push_back(seq[i]);
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== seq[i] || level !== 4'd1) begin
        miscompares++;
        $display("[TB] FAIL order_step%0d: got valid=%b data=%h level=%0d, required valid=1 data=%h level=1",
                 i, out_valid, out_data, level, seq[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (level !== 4'd0 || out_valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL order_empty: got level=%0d valid=%b pending=%0d, required 0 0 0",
               level, out_valid, exp_q.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full_stall();
    bit took;
    int n;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h30 + 8'(i);
      exp_q.push_back(8'h30 + 8'(i));
      tick();
      vectors++;
      if (level !== 4'(i + 1) || high_water !== (i == DEPTH - 1) || in_ready !== (i < DEPTH - 1)) begin
        miscompares++;
        $display("[TB] FAIL fill_%0d: got level=%0d hw=%b rdy=%b, required level=%0d hw=%b rdy=%b",
                 i, level, high_water, in_ready, i + 1, (i == DEPTH - 1), (i < DEPTH - 1));
      end
    end
    in_data = 8'h5A;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (in_ready !== 1'b0 || level !== 4'd8 || out_valid !== 1'b1 || out_data !== 8'h30) begin
        miscompares++;
        $display("[TB] FAIL stall_%0d: got rdy=%b level=%0d valid=%b data=%h, required 0 8 1 30",
                 c, in_ready, level, out_valid, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    took = 1'b0;
    n = 0;
    while (!took && n < 4) begin
      took = (in_ready === 1'b1);
      if (took) exp_q.push_back(8'h5A);
      tick();
      n++;
    end
    in_valid = 1'b0;
    vectors++;
    if (!took || n != 2) begin
      miscompares++;
      $display("[TB] FAIL ninth_accept: got accepted=%b after %0d cycles, required accepted=1 after 2",
               took, n);
    end
    drain("full_stall");
    vectors++;
    if (high_water !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL high_water_sticky: got %b, required 1", high_water);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(i);
      exp_q.push_back(8'hA0 + 8'(i));
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (level !== 4'd5) begin
      miscompares++;
      $display("[TB] FAIL mid_level: got %0d, required 5", level);
    end
    out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || level !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got valid=%b level=%0d, required 0 0", out_valid, level);
    end
    exp_q.delete();
    #2;
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data  = 8'h51;
    exp_q.push_back(8'h51);
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'h51 || level !== 4'd1) begin
      miscompares++;
      $display("[TB] FAIL mid_repush: got valid=%b data=%h level=%0d, required 1 51 1",
               out_valid, out_data, level);
    end
    drain("reset_mid");
  endtask

  task automatic test_watchdog();
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == WDOG) exp_q.push_back(STOP);
      vectors++;
      if (wdog_fired !== (k == WDOG) || level !== ((k > WDOG) ? 4'd1 : 4'd0)) begin
        miscompares++;
        $display("[TB] FAIL wdog_cycle%0d: got wf=%b level=%0d, required wf=%b level=%0d",
                 k, wdog_fired, level, (k == WDOG), (k > WDOG) ? 1 : 0);
      end
    end
    for (int k = 0; k < 100; k++) begin
      tick();
      vectors++;
      if (wdog_fired !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL wdog_repeat%0d: got wf=%b, required 0", k, wdog_fired);
      end
    end
    vectors++;
    if (level !== 4'd1 || out_data !== STOP) begin
      miscompares++;
      $display("[TB] FAIL wdog_single: got level=%0d data=%h, required 1 %h", level, out_data, STOP);
    end
    drain("watchdog");
  endtask

  task automatic test_wdog_race();
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= WDOG; k++) tick();
    vectors++;
    if (wdog_fired !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL race_pending: got wf=%b, required 1", wdog_fired);
    end
    in_valid = 1'b1;
    in_data  = 8'h58;
    #1;
    vectors++;
    if (wdog_fired !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL race_yield: got wf=%b, required 0", wdog_fired);
    end
    exp_q.push_back(8'h58);
    tick();
    in_valid = 1'b0;
    for (int j = 1; j <= WDOG; j++) begin
      tick();
      if (j == WDOG) exp_q.push_back(STOP);
      vectors++;
      if (wdog_fired !== (j == WDOG)) begin
        miscompares++;
        $display("[TB] FAIL race_rearm%0d: got wf=%b, required %b", j, wdog_fired, (j == WDOG));
      end
    end
    tick();
    drain("wdog_race");
  endtask

  task automatic test_wdog_full();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h61 + 8'(i);
      exp_q.push_back(8'h61 + 8'(i));
      tick();
    end
    in_valid = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      vectors++;
      if (wdog_fired !== 1'b0 || level !== 4'd8) begin
        miscompares++;
        $display("[TB] FAIL full_wait%0d: got wf=%b level=%0d, required 0 8", j, wdog_fired, level);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (level !== 4'd7 || wdog_fired !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL full_pop: got level=%0d wf=%b, required 7 1", level, wdog_fired);
    end
    exp_q.push_back(STOP);
    tick();
    vectors++;
    if (level !== 4'd8 || wdog_fired !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_inject: got level=%0d wf=%b rdy=%b, required 8 0 0",
               level, wdog_fired, in_ready);
    end
    drain("wdog_full");
  endtask

  initial begin
    test_reset();
    test_order();
    test_full_stall();
    test_reset_mid();
    test_watchdog();
    test_wdog_race();
    test_wdog_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
